// File: rtl/nco_select_scheduler.sv
// Table-driven sequencer for the NCO waveform select: steps through (select, dwell)
// entries, once or looping, holding every applied select for at least MIN_DWELL cycles.
module nco_select_scheduler #(
   parameter int unsigned SELECT_WIDTH = 3,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned DWELL_WIDTH  = 16,
   parameter int unsigned MIN_DWELL    = 32
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
   input  logic [SELECT_WIDTH-1:0]    cfg_sel,
   input  logic [DWELL_WIDTH-1:0]     cfg_dwell,
   input  logic                       start,
   input  logic [$clog2(DEPTH):0]     len,
   input  logic                       loop,
   input  logic                       stop,
   output logic [SELECT_WIDTH-1:0]    signal_out,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH)-1:0]   cur_idx,
   output logic                       cfg_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned LEN_W = IDX_W + 1;
   localparam int unsigned SW    = SELECT_WIDTH;
   localparam int unsigned DW    = DWELL_WIDTH;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_n;
   logic [SW-1:0]     sel_tab   [DEPTH];
   logic [DW-1:0]     dwell_tab [DEPTH];
   logic [DW-1:0]     cnt, cnt_n;
   logic [IDX_W-1:0]  idx_n, nxt_idx_c;
   logic [LEN_W-1:0]  len_q, len_n;
   logic              loop_q, loop_n, stop_q, stop_n;
   logic [SW-1:0]     sel_n;
   logic              busy_n, done_n, err_n;
   logic              wr_c, len_ok_c, last_c, stop_any_c;

   // Counter preload for an entry: dwell clamped up to MIN_DWELL, minus one.
   function automatic logic [DW-1:0] eff_cnt(input logic [DW-1:0] d);
      return (d < DW'(MIN_DWELL)) ? DW'(MIN_DWELL - 1) : d - DW'(1);
   endfunction

   assign len_ok_c   = (len != LEN_W'(0)) && (len <= LEN_W'(DEPTH));
   assign last_c     = (LEN_W'(cur_idx) == len_q - LEN_W'(1));
   assign nxt_idx_c  = cur_idx + IDX_W'(1);
   assign stop_any_c = stop_q | stop;

   // Next-state and next-output logic.
   always_comb begin
      state_n = state;
      sel_n   = signal_out;
      cnt_n   = cnt;
      idx_n   = cur_idx;
      len_n   = len_q;
      loop_n  = loop_q;
      stop_n  = stop_q;
      busy_n  = busy;
      done_n  = 1'b0;
      err_n   = 1'b0;
      wr_c    = 1'b0;
      case (state)
         IDLE: begin
            stop_n = 1'b0;
            if (start) begin
               err_n = cfg_we | ~len_ok_c;
               if (len_ok_c) begin
                  sel_n   = sel_tab[0];
                  idx_n   = '0;
                  cnt_n   = eff_cnt(dwell_tab[0]);
                  busy_n  = 1'b1;
                  len_n   = len;
                  loop_n  = loop;
                  state_n = RUN;
               end
            end else if (cfg_we) begin
               wr_c = 1'b1;
            end
         end
         RUN: begin
            err_n = cfg_we;
            if (stop) stop_n = 1'b1;
            if (cnt != DW'(0)) begin
               cnt_n = cnt - DW'(1);
            end else if (stop_any_c || (last_c && !loop_q)) begin
               // A pending stop makes the entry just finished the final one.
               busy_n  = 1'b0;
               done_n  = 1'b1;
               stop_n  = 1'b0;
               state_n = IDLE;
            end else if (last_c) begin
               idx_n = '0;
               sel_n = sel_tab[0];
               cnt_n = eff_cnt(dwell_tab[0]);
            end else begin
               idx_n = nxt_idx_c;
               sel_n = sel_tab[nxt_idx_c];
               cnt_n = eff_cnt(dwell_tab[nxt_idx_c]);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         signal_out <= '0;
         cnt        <= '0;
         cur_idx    <= '0;
         len_q      <= '0;
         loop_q     <= 1'b0;
         stop_q     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         state      <= state_n;
         signal_out <= sel_n;
         cnt        <= cnt_n;
         cur_idx    <= idx_n;
         len_q      <= len_n;
         loop_q     <= loop_n;
         stop_q     <= stop_n;
         busy       <= busy_n;
         done       <= done_n;
         cfg_err    <= err_n;
      end
   end

   // Entry table, cleared by reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            sel_tab[i]   <= '0;
            dwell_tab[i] <= '0;
         end
      end else if (wr_c) begin
         sel_tab[cfg_addr]   <= cfg_sel;
         dwell_tab[cfg_addr] <= cfg_dwell;
      end
   end

endmodule

// File: tb/tb_nco_select_scheduler.sv
// Directed bench for nco_select_scheduler: hand-computed change times, done timing and error pulses.
module tb_nco_select_scheduler;

   logic       clk = 1'b0;
   logic       resetn, cfg_we, start, loop, stop;
   logic [2:0] cfg_addr, cfg_sel;
   logic [15:0] cfg_dwell;
   logic [3:0] len;
   logic [2:0] signal_out, cur_idx;
   logic       busy, done, cfg_err;

   int vectors = 0;
   int miscompares = 0;
   int chg_k[$], chg_v[$], idx_k[$], idx_v[$];
   int done_at;

   nco_select_scheduler dut (
      .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_sel(cfg_sel), .cfg_dwell(cfg_dwell), .start(start), .len(len),
      .loop(loop), .stop(stop), .signal_out(signal_out), .busy(busy),
      .done(done), .cur_idx(cur_idx), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int s, input int d);
      cfg_we = 1'b1; cfg_addr = 3'(a); cfg_sel = 3'(s); cfg_dwell = 16'(d);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic go(input int l, input bit lp);
      start = 1'b1; len = 4'(l); loop = lp;
      tick();
      start = 1'b0;
   endtask

   // Steps after a start edge, logging select/index changes by edge number until done.
   task automatic watch(input string tag, input int bound, input int stop_at);
      int ps, pi;
      chg_k.delete(); chg_v.delete(); idx_k.delete(); idx_v.delete();
      done_at = -1;
      ps = int'(signal_out);
      pi = int'(cur_idx);
      for (int k = 1; k <= bound; k++) begin
         stop = (k == stop_at);
         tick();
         stop = 1'b0;
         if (int'(signal_out) != ps) begin chg_k.push_back(k); chg_v.push_back(int'(signal_out)); end
         if (int'(cur_idx) != pi) begin idx_k.push_back(k); idx_v.push_back(int'(cur_idx)); end
         ps = int'(signal_out);
         pi = int'(cur_idx);
         if (done) begin
            done_at = k;
            break;
         end
      end
      chk({tag, " busy_at_done"}, int'(busy), 0);
      tick();
      chk({tag, " done_1cyc"}, int'(done), 0);
   endtask

   initial begin
      resetn = 1'b0; cfg_we = 1'b0; start = 1'b0; loop = 1'b0; stop = 1'b0;
      cfg_addr = '0; cfg_sel = '0; cfg_dwell = '0; len = '0;

      tick(); tick();
      chk("rst sel", int'(signal_out), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst err", int'(cfg_err), 0);
      chk("rst idx", int'(cur_idx), 0);
      resetn = 1'b1;
      tick();

      // One pass with clamping of the short dwell.
      wr(0, 1, 40); wr(1, 2, 5); wr(2, 3, 32);
      go(3, 1'b0);
      chk("p1 sel0", int'(signal_out), 1);
      chk("p1 busy", int'(busy), 1);
      watch("p1", 200, -1);
      chk("p1 nchg", chg_k.size(), 2);
      chk("p1 chg0 k", chg_k[0], 40); chk("p1 chg0 v", chg_v[0], 2);
      chk("p1 chg1 k", chg_k[1], 72); chk("p1 chg1 v", chg_v[1], 3);
      chk("p1 idx0 k", idx_k[0], 40); chk("p1 idx1 k", idx_k[1], 72);
      chk("p1 done_at", done_at, 104);
      chk("p1 sel_end", int'(signal_out), 3);

      // Looping run ended by stop during the second pass of entry 0.
      wr(0, 4, 33); wr(1, 5, 33);
      go(2, 1'b1);
      chk("lp sel0", int'(signal_out), 4);
      watch("lp", 200, 77);
      chk("lp nchg", chg_k.size(), 2);
      chk("lp chg0 k", chg_k[0], 33); chk("lp chg0 v", chg_v[0], 5);
      chk("lp chg1 k", chg_k[1], 66); chk("lp chg1 v", chg_v[1], 4);
      chk("lp done_at", done_at, 99);
      chk("lp sel_end", int'(signal_out), 4);
      chk("lp idx_end", int'(cur_idx), 0);

      // Rejected commands.
      go(0, 1'b0);
      chk("len0 err", int'(cfg_err), 1); chk("len0 busy", int'(busy), 0);
      tick();
      chk("len0 err_clr", int'(cfg_err), 0);
      go(9, 1'b0);
      chk("len9 err", int'(cfg_err), 1); chk("len9 busy", int'(busy), 0);
      tick();
      chk("len9 err_clr", int'(cfg_err), 0);
      go(2, 1'b0);
      chk("wrrun err0", int'(cfg_err), 0);
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_sel = 3'd7; cfg_dwell = 16'd0;
      tick();
      cfg_we = 1'b0;
      chk("wrrun err", int'(cfg_err), 1);
      tick();
      chk("wrrun err_clr", int'(cfg_err), 0);
      watch("wrrun", 200, -1);
      chk("wrrun done_at", done_at, 64);
      chk("wrrun sel_end", int'(signal_out), 5);
      go(1, 1'b0);
      chk("keep sel0", int'(signal_out), 4);
      watch("keep", 200, -1);
      chk("keep nchg", chg_k.size(), 0);
      chk("keep done_at", done_at, 33);

      // Reset mid-run clears the table and aborts without done.
      wr(0, 6, 100);
      go(1, 1'b0);
      chk("mr sel0", int'(signal_out), 6);
      for (int k = 1; k < 20; k++) tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      chk("mr sel", int'(signal_out), 0);
      chk("mr busy", int'(busy), 0);
      chk("mr done", int'(done), 0);
      tick();
      chk("mr done_next", int'(done), 0);
      go(1, 1'b0);
      chk("mr2 sel0", int'(signal_out), 0);
      chk("mr2 busy", int'(busy), 1);
      watch("mr2", 200, -1);
      chk("mr2 nchg", chg_k.size(), 0);
      chk("mr2 done_at", done_at, 32);

      // Equal consecutive selects give no visible change.
      wr(0, 2, 32); wr(1, 2, 32); wr(2, 6, 0);
      go(3, 1'b0);
      chk("eq sel0", int'(signal_out), 2);
      chk("eq idx0", int'(cur_idx), 0);
      watch("eq", 200, -1);
      chk("eq nchg", chg_k.size(), 1);
      chk("eq chg0 k", chg_k[0], 64); chk("eq chg0 v", chg_v[0], 6);
      chk("eq idx0 k", idx_k[0], 32); chk("eq idx0 v", idx_v[0], 1);
      chk("eq idx1 k", idx_k[1], 64); chk("eq idx1 v", idx_v[1], 2);
      chk("eq done_at", done_at, 96);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
